alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 77 +++++++
 tb/tb_alu_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared combinational ALU (req0/req1 in, shared alu_* out, rsp0/rsp1 with shared rsp_data_o/rsp_zero_o back, busy_o)
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 7,
  parameter int ZCMD_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_rs1_i,
  input  logic [DATA_W-1:0] req0_rs2_i,
  input  logic [CMD_W-1:0]  req0_alu_cmd_i,
  input  logic [ZCMD_W-1:0] req0_zero_cmd_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_rs1_i,
  input  logic [DATA_W-1:0] req1_rs2_i,
  input  logic [CMD_W-1:0]  req1_alu_cmd_i,
  input  logic [ZCMD_W-1:0] req1_zero_cmd_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_zero_o,
  output logic [DATA_W-1:0] alu_rs1_o,
  output logic [DATA_W-1:0] alu_rs2_o,
  output logic [CMD_W-1:0]  alu_cmd_o,
  output logic [ZCMD_W-1:0] alu_zero_cmd_o,
  input  logic [DATA_W-1:0] alu_rd_data_i,
  input  logic              alu_zero_i,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic owner, last_owner, grant0, grant1;
  always_comb begin
    grant0 = req0_valid_i & (~req1_valid_i | last_owner);
    grant1 = req1_valid_i & (~req0_valid_i | ~last_owner);
    req0_ready_o = (state == IDLE) & grant0;
    req1_ready_o = (state == IDLE) & grant1;
    rsp0_valid_o = (state == RESP) & ~owner;
    rsp1_valid_o = (state == RESP) & owner;
    busy_o = state != IDLE;
    state_n = state == IDLE ? ((grant0 | grant1) ? EXEC : IDLE) :
              state == EXEC ? RESP :
              ((owner ? rsp1_ready_i : rsp0_ready_i) ? IDLE : RESP);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      owner <= 1'b0;
      last_owner <= 1'b1;
      alu_rs1_o <= '0;
      alu_rs2_o <= '0;
      alu_cmd_o <= '0;
      alu_zero_cmd_o <= '0;
      rsp_data_o <= '0;
      rsp_zero_o <= 1'b0;
    end else begin
      state <= state_n;
      if (req0_ready_o | req1_ready_o) begin
        owner <= req1_ready_o;
        last_owner <= req1_ready_o;
        alu_rs1_o <= req1_ready_o ? req1_rs1_i : req0_rs1_i;
        alu_rs2_o <= req1_ready_o ? req1_rs2_i : req0_rs2_i;
        alu_cmd_o <= req1_ready_o ? req1_alu_cmd_i : req0_alu_cmd_i;
        alu_zero_cmd_o <= req1_ready_o ? req1_zero_cmd_i : req0_zero_cmd_i;
      end
      if (state == EXEC) begin
        rsp_data_o <= alu_rd_data_i;
        rsp_zero_o <= alu_zero_i;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with an adder ALU stub
module tb_alu_arbiter;
  logic clk = 0, rst_n = 0;
  logic v0 = 0, v1 = 0, r0, r1;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [6:0] c0 = 0, c1 = 0;
  logic [2:0] z0 = 0, z1 = 0;
  logic p0, p1, q0 = 1, q1 = 1;
  logic [31:0] rdata, ars1, ars2, sum;
  logic rzero, busy;
  logic [6:0] acmd;
  logic [2:0] azcmd;
  int checks = 0, failures = 0;
  assign sum = ars1 + ars2;
  alu_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_rs1_i(a0), .req0_rs2_i(b0),
    .req0_alu_cmd_i(c0), .req0_zero_cmd_i(z0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_rs1_i(a1), .req1_rs2_i(b1),
    .req1_alu_cmd_i(c1), .req1_zero_cmd_i(z1),
    .rsp0_valid_o(p0), .rsp0_ready_i(q0), .rsp1_valid_o(p1), .rsp1_ready_i(q1),
    .rsp_data_o(rdata), .rsp_zero_o(rzero),
    .alu_rs1_o(ars1), .alu_rs2_o(ars2), .alu_cmd_o(acmd), .alu_zero_cmd_o(azcmd),
    .alu_rd_data_i(sum), .alu_zero_i(sum == 32'd0), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    step();
    rst_n = 1;
    chk("rst_busy", busy, 0);
    chk("rst_p0", p0, 0);
    chk("rst_p1", p1, 0);
    chk("rst_data", rdata, 0);
    chk("rst_zero", rzero, 0);
    chk("rst_alu_rs1", ars1, 0);
    chk("rst_alu_cmd", acmd, 0);
    v0 = 1; a0 = 5; b0 = 3; c0 = 7'h15; z0 = 3'h2;
    #1;
    chk("t1_ready0", r0, 1);
    chk("t1_ready1", r1, 0);
    step();
    v0 = 0;
    chk("t1_exec_busy", busy, 1);
    chk("t1_exec_ready0", r0, 0);
    chk("t1_alu_rs1", ars1, 5);
    chk("t1_alu_cmd", acmd, 7'h15);
    chk("t1_alu_zcmd", azcmd, 3'h2);
    chk("t1_exec_p0", p0, 0);
    step();
    chk("t1_p0", p0, 1);
    chk("t1_p1", p1, 0);
    chk("t1_data", rdata, 8);
    chk("t1_zero", rzero, 0);
    step();
    chk("t1_done_busy", busy, 0);
    chk("t1_done_p0", p0, 0);
    rst_n = 0;
    step();
    rst_n = 1;
    v0 = 1; a0 = 1; b0 = 2; v1 = 1; a1 = 10; b1 = 20;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tie_ready0", r0, (i % 2 == 0) ? 1 : 0);
      chk("tie_ready1", r1, (i % 2 == 1) ? 1 : 0);
      step();
      chk("tie_exec_ready", {r0, r1}, 0);
      step();
      chk("tie_p0", p0, (i % 2 == 0) ? 1 : 0);
      chk("tie_p1", p1, (i % 2 == 1) ? 1 : 0);
      chk("tie_data", rdata, (i % 2 == 0) ? 3 : 30);
      step();
    end
    v0 = 0; v1 = 1; a1 = 32'hFFFFFFFF; b1 = 1;
    #1;
    chk("t3_ready1", r1, 1);
    step();
    v1 = 0;
    step();
    chk("t3_p1", p1, 1);
    chk("t3_p0", p0, 0);
    chk("t3_data", rdata, 0);
    chk("t3_zero", rzero, 1);
    step();
    q0 = 0; v0 = 1; a0 = 32'h100; b0 = 32'h23;
    step();
    v0 = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      v0 = 1; a0 = 32'hDEAD0000 + i; q1 = 1;
      #1;
      chk("hold_p0", p0, 1);
      chk("hold_data", rdata, 32'h123);
      chk("hold_ready", {r0, r1}, 0);
      chk("hold_busy", busy, 1);
      chk("hold_alu_rs1", ars1, 32'h100);
      step();
    end
    v0 = 0; q0 = 1;
    step();
    chk("hold_exit_busy", busy, 0);
    v0 = 1; a0 = 4; b0 = 4;
    step();
    v0 = 0; rst_n = 0;
    step();
    rst_n = 1;
    chk("exec_rst_busy", busy, 0);
    chk("exec_rst_p0", p0, 0);
    chk("exec_rst_data", rdata, 0);
    chk("exec_rst_alu", ars1, 0);
    v0 = 1; v1 = 1;
    #1;
    chk("exec_rst_tie_ready0", r0, 1);
    v0 = 0; v1 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("exec_rst_no_rsp", {p0, p1}, 0);
    end
    q1 = 0; v1 = 1; a1 = 2; b1 = 2;
    step();
    v1 = 0; v0 = 1; a0 = 32'h55;
    step();
    v0 = 0; q1 = 1;
    chk("pulse_p1", p1, 1);
    chk("pulse_data", rdata, 4);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("pulse_no_p0", p0, 0);
      chk("pulse_idle", busy, 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
